// File: rtl/monit_pkg.sv
// Shared types and UART framing constants for the monitoring-buffer drain path.
package monit_pkg;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    WAIT,
    SEND
  } state_t;

  localparam logic START_BIT     = 1'b0;
  localparam logic STOP_BIT      = 1'b1;
  localparam int   BITS_PER_BYTE = 8;
  // start bit + data bits + stop bit
  localparam int   FRAME_BITS    = BITS_PER_BYTE + 2;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte UART 8N1 transmitter. The tx line is driven from a flop.
// ready rises on the last cycle of the stop bit, so a parent can chain
// bytes with no idle gap between them.
import monit_pkg::*;

module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

  logic                     active;
  logic [CNT_W-1:0]         clk_cnt;
  logic [3:0]               bit_idx;
  logic [BITS_PER_BYTE:0]   shreg;
  logic                     bit_end;
  logic                     load;

  assign bit_end = (clk_cnt == CNT_LAST);
  assign ready   = !active || (bit_end && (bit_idx == BIT_LAST));
  assign load    = start && ready;

  // Bit timing, bit index and the registered serial line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active  <= 1'b0;
      clk_cnt <= '0;
      bit_idx <= '0;
      tx      <= STOP_BIT;
    end else if (load) begin
      active  <= 1'b1;
      clk_cnt <= '0;
      bit_idx <= '0;
      tx      <= START_BIT;
    end else if (active) begin
      if (bit_end) begin
        clk_cnt <= '0;
        if (bit_idx == BIT_LAST) begin
          active <= 1'b0;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          tx      <= shreg[0];
        end
      end else begin
        clk_cnt <= clk_cnt + CNT_W'(1);
      end
    end
  end

  // Payload shifter: data bits LSB first, stop bit shifted in behind them.
  always_ff @(posedge clk) begin
    if (load) begin
      shreg <= {STOP_BIT, data};
    end else if (active && bit_end) begin
      shreg <= {STOP_BIT, shreg[BITS_PER_BYTE:1]};
    end
  end

endmodule

// File: rtl/buffer_uart_drain.sv
// Drains the monitoring data buffer one word at a time and sends each word
// as a UART frame: optional sync byte, then data bytes LSB first.
// The first byte of a frame is handed to the transmitter in WAIT (using
// buf_data directly while it is valid), which keeps the idle gap between
// frames at exactly IDLE + POP + WAIT.
import monit_pkg::*;

module buffer_uart_drain #(
  parameter int         VARIABLE_LENGTH_BITS = 32,
  parameter int         CLKS_PER_BIT         = 868,
  parameter int         SYNC_EN              = 1,
  parameter logic [7:0] SYNC_BYTE            = DEFAULT_SYNC_BYTE
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic                            buf_empty,
  input  logic [VARIABLE_LENGTH_BITS-1:0] buf_data,
  output logic                            rd_enable,
  output logic                            tx,
  output logic                            busy,
  output logic [31:0]                     words_sent
);

  localparam int DATA_BYTES = VARIABLE_LENGTH_BITS / BITS_PER_BYTE;
  localparam int REM_W      = $clog2(DATA_BYTES + 1);
  // Bytes still to issue once the first byte has gone out in WAIT.
  localparam logic [REM_W-1:0] REM_INIT =
    REM_W'((SYNC_EN != 0) ? DATA_BYTES : DATA_BYTES - 1);

  state_t                          state;
  state_t                          next_state;
  logic [VARIABLE_LENGTH_BITS-1:0] word_q;
  logic [REM_W-1:0]                rem_q;
  logic                            byte_start;
  logic                            byte_ready;
  logic [7:0]                      byte_data;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and byte hand-off to the transmitter.
  always_comb begin
    next_state = state;
    byte_start = 1'b0;
    byte_data  = word_q[7:0];
    case (state)
      IDLE: begin
        if (enable && !buf_empty) begin
          next_state = POP;
        end
      end
      POP: begin
        next_state = WAIT;
      end
      WAIT: begin
        byte_start = 1'b1;
        byte_data  = (SYNC_EN != 0) ? SYNC_BYTE : buf_data[7:0];
        next_state = SEND;
      end
      SEND: begin
        if (byte_ready) begin
          if (rem_q != '0) begin
            byte_start = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Word shift register: captured in WAIT, advanced one byte per issue.
  always_ff @(posedge clk) begin
    if (state == WAIT) begin
      word_q <= (SYNC_EN != 0) ? buf_data : (buf_data >> BITS_PER_BYTE);
    end else if (state == SEND && byte_ready && rem_q != '0) begin
      word_q <= word_q >> BITS_PER_BYTE;
    end
  end

  // Remaining-byte count and completed-frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q      <= '0;
      words_sent <= '0;
    end else if (state == WAIT) begin
      rem_q <= REM_INIT;
    end else if (state == SEND && byte_ready) begin
      if (rem_q != '0) begin
        rem_q <= rem_q - REM_W'(1);
      end else begin
        words_sent <= words_sent + 32'd1;
      end
    end
  end

  assign rd_enable = (state == POP);
  assign busy      = (state != IDLE);

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .start(byte_start),
    .data (byte_data),
    .tx   (tx),
    .ready(byte_ready)
  );

endmodule

// File: tb/tb_buffer_uart_drain.sv
// Bench for buffer_uart_drain: two instances (sync byte on / off), a queue
// model of the data buffer for each, and a free-running UART line decoder.
module tb_buffer_uart_drain;

  localparam int CPB = 4;
  localparam int W   = 32;
  localparam int BIT_SPAN = 10 * CPB;

  typedef struct {
    logic [7:0] b;
    int         st;
  } rxb_t;

  typedef struct {
    logic [31:0] word;
    logic [39:0] bytes;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable0 = 1'b0;
  logic          enable1 = 1'b0;
  logic          buf_empty0 = 1'b1;
  logic          buf_empty1 = 1'b1;
  logic [W-1:0]  buf_data0 = '0;
  logic [W-1:0]  buf_data1 = '0;
  logic          rd0, rd1, tx0, tx1, busy0, busy1;
  logic [31:0]   ws0, ws1;

  logic [W-1:0]  q0[$];
  logic [W-1:0]  q1[$];
  rxb_t          rx0[$];
  rxb_t          rx1[$];

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int empty_pop = 0;
  int framing_err = 0;
  int rise0 = 0, hi0 = 0, txlow0 = 0, rise1 = 0;
  logic prev0 = 1'b0, prev1 = 1'b0;

  bit         rbusy[2];
  int         rcnt[2];
  logic [7:0] rsh[2];
  int         rstart[2];

  vec_t vecs[4];

  buffer_uart_drain #(
    .VARIABLE_LENGTH_BITS(W), .CLKS_PER_BIT(CPB), .SYNC_EN(1), .SYNC_BYTE(8'hA5)
  ) u0 (
    .clk(clk), .rst(rst), .enable(enable0), .buf_empty(buf_empty0),
    .buf_data(buf_data0), .rd_enable(rd0), .tx(tx0), .busy(busy0),
    .words_sent(ws0)
  );

  buffer_uart_drain #(
    .VARIABLE_LENGTH_BITS(W), .CLKS_PER_BIT(CPB), .SYNC_EN(0), .SYNC_BYTE(8'hA5)
  ) u1 (
    .clk(clk), .rst(rst), .enable(enable1), .buf_empty(buf_empty1),
    .buf_data(buf_data1), .rd_enable(rd1), .tx(tx1), .busy(busy1),
    .words_sent(ws1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Buffer model: registered output, updated at the edge ending a pop.
  always @(posedge clk) begin
    if (rd0) begin
      if (q0.size() != 0) buf_data0 <= q0.pop_front();
      else empty_pop <= empty_pop + 1;
    end
    if (rd1) begin
      if (q1.size() != 0) buf_data1 <= q1.pop_front();
      else empty_pop <= empty_pop + 1;
    end
  end

  // Line decoder and pop/line activity counters, sampled on the falling edge.
  always @(negedge clk) begin
    logic [1:0] txv;
    rxb_t e;
    txv = {tx1, tx0};
    buf_empty0 = (q0.size() == 0);
    buf_empty1 = (q1.size() == 0);
    if (rd0 && !prev0) rise0++;
    if (rd0) hi0++;
    if (tx0 === 1'b0) txlow0++;
    if (rd1 && !prev1) rise1++;
    prev0 = rd0;
    prev1 = rd1;
    if (rst) begin
      rbusy[0] = 1'b0;
      rbusy[1] = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!rbusy[i]) begin
          if (txv[i] === 1'b0) begin
            rbusy[i]  = 1'b1;
            rcnt[i]   = 0;
            rstart[i] = cyc;
          end
        end else begin
          rcnt[i]++;
          if (rcnt[i] == 2 && txv[i] !== 1'b0) framing_err++;
          if (rcnt[i] >= 6 && rcnt[i] <= 34 && (rcnt[i] % 4) == 2)
            rsh[i] = {txv[i], rsh[i][7:1]};
          if (rcnt[i] == 38) begin
            if (txv[i] !== 1'b1) framing_err++;
            e.b  = rsh[i];
            e.st = rstart[i];
            if (i == 0) rx0.push_back(e);
            else rx1.push_back(e);
            rbusy[i] = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_sent(input int which, input logic [31:0] target, input int budget,
                           input string name);
    int n = 0;
    while (((which == 0) ? ws0 : ws1) != target && n < budget) begin
      tick();
      n++;
    end
    check(name, (which == 0) ? ws0 : ws1, target);
  endtask

  task automatic check_frame(input string name, input int which, input int base,
                             input int nbytes, input logic [39:0] exp);
    rxb_t e;
    rxb_t f;
    int   sz;
    sz = (which == 0) ? rx0.size() : rx1.size();
    f.b = 'x;
    f.st = 0;
    for (int k = 0; k < nbytes; k++) begin
      if (base + k < sz) e = (which == 0) ? rx0[base + k] : rx1[base + k];
      else e = '{b: 8'hxx, st: 0};
      if (k == 0) f = e;
      check($sformatf("%s_byte%0d", name, k), e.b, exp[8*(nbytes-1-k) +: 8]);
    end
    check($sformatf("%s_len", name), e.st + BIT_SPAN - f.st, nbytes * BIT_SPAN);
  endtask

  initial begin
    int base_rx, base_rise, base_hi, base_low, n;
    logic [31:0] base_ws;

    vecs[0] = '{word: 32'h12345678, bytes: 40'hA5_78_56_34_12};
    vecs[1] = '{word: 32'h00000000, bytes: 40'hA5_00_00_00_00};
    vecs[2] = '{word: 32'hA5A5A5A5, bytes: 40'hA5_A5_A5_A5_A5};
    vecs[3] = '{word: 32'h0F1E2D3C, bytes: 40'hA5_3C_2D_1E_0F};

    // Reset held for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_tx", tx0, 1);
      check("rst_rd", rd0, 0);
    end
    check("rst_busy", busy0, 0);
    check("rst_words", ws0, 0);
    rst = 1'b0;
    tick();
    check("post_rst_tx", tx0, 1);

    // Single words from the table.
    enable0 = 1'b1;
    for (int v = 0; v < 4; v++) begin
      base_rx   = rx0.size();
      base_rise = rise0;
      base_hi   = hi0;
      base_ws   = ws0;
      q0.push_back(vecs[v].word);
      wait_sent(0, base_ws + 1, 1000, $sformatf("vec%0d_done", v));
      tick();
      check($sformatf("vec%0d_pops", v), rise0 - base_rise, 1);
      check($sformatf("vec%0d_popw", v), hi0 - base_hi, 1);
      check($sformatf("vec%0d_nbytes", v), rx0.size() - base_rx, 5);
      check_frame($sformatf("vec%0d", v), 0, base_rx, 5, vecs[v].bytes);
      check($sformatf("vec%0d_busy", v), busy0, 0);
      check($sformatf("vec%0d_tx", v), tx0, 1);
    end

    // Empty buffer: nothing popped, line stays high.
    base_rise = rise0;
    base_hi   = hi0;
    base_low  = txlow0;
    repeat (1000) tick();
    check("empty_pops", rise0 - base_rise, 0);
    check("empty_rdhi", hi0 - base_hi, 0);
    check("empty_txlow", txlow0 - base_low, 0);
    check("empty_busy", busy0, 0);

    // Burst of three words with minimum inter-frame gap.
    enable0 = 1'b0;
    base_rx   = rx0.size();
    base_rise = rise0;
    base_ws   = ws0;
    q0.push_back(32'h00000001);
    q0.push_back(32'hDEADBEEF);
    q0.push_back(32'hFFFFFFFF);
    tick();
    enable0 = 1'b1;
    wait_sent(0, base_ws + 3, 3000, "burst_done");
    tick();
    check("burst_pops", rise0 - base_rise, 3);
    check("burst_nbytes", rx0.size() - base_rx, 15);
    check_frame("burst_f0", 0, base_rx, 5, 40'hA5_01_00_00_00);
    check_frame("burst_f1", 0, base_rx + 5, 5, 40'hA5_EF_BE_AD_DE);
    check_frame("burst_f2", 0, base_rx + 10, 5, 40'hA5_FF_FF_FF_FF);
    check("burst_gap1", rx0[base_rx + 5].st - (rx0[base_rx + 4].st + BIT_SPAN), 3);
    check("burst_gap2", rx0[base_rx + 10].st - (rx0[base_rx + 9].st + BIT_SPAN), 3);
    check("burst_buf_left", q0.size(), 0);

    // Enable dropped during the second byte of a frame with two words queued.
    enable0 = 1'b0;
    base_rx   = rx0.size();
    base_rise = rise0;
    base_ws   = ws0;
    q0.push_back(32'h01020304);
    q0.push_back(32'h0A0B0C0D);
    tick();
    enable0 = 1'b1;
    n = 0;
    while (rx0.size() < base_rx + 1 && n < 500) begin
      tick();
      n++;
    end
    check("drop_sync_seen", rx0.size() - base_rx, 1);
    repeat (12) tick();
    enable0 = 1'b0;
    wait_sent(0, base_ws + 1, 1000, "drop_done");
    repeat (100) tick();
    check("drop_words", ws0, base_ws + 1);
    check("drop_pops", rise0 - base_rise, 1);
    check("drop_buf_left", q0.size(), 1);
    check_frame("drop_f0", 0, base_rx, 5, 40'hA5_04_03_02_01);
    check("drop_busy", busy0, 0);
    q0.delete();

    // Reset during data bit 3 of the sync byte, then a clean frame.
    enable0 = 1'b1;
    q0.push_back(32'h11223344);
    n = 0;
    while (!rbusy[0] && n < 500) begin
      tick();
      n++;
    end
    check("midrst_started", rbusy[0], 1);
    n = 0;
    while (cyc < rstart[0] + 17 && n < 100) begin
      tick();
      n++;
    end
    check("midrst_tx_before", tx0, 0);
    rst = 1'b1;
    #1;
    check("midrst_tx", tx0, 1);
    check("midrst_busy", busy0, 0);
    check("midrst_words", ws0, 0);
    repeat (2) tick();
    check("midrst_rd", rd0, 0);
    rst = 1'b0;
    base_rx = rx0.size();
    q0.push_back(32'hCAFEF00D);
    wait_sent(0, 1, 1000, "midrst_done");
    tick();
    check("midrst_nbytes", rx0.size() - base_rx, 5);
    check_frame("midrst_f0", 0, base_rx, 5, 40'hA5_0D_F0_FE_CA);

    // Instance without the sync byte.
    base_rx = rx1.size();
    enable1 = 1'b1;
    q1.push_back(32'h12345678);
    wait_sent(1, 1, 1000, "nosync_done");
    tick();
    check("nosync_pops", rise1, 1);
    check("nosync_nbytes", rx1.size() - base_rx, 4);
    check_frame("nosync_f0", 1, base_rx, 4, 40'h00_78_56_34_12);
    check("nosync_busy", busy1, 0);

    check("framing_errors", framing_err, 0);
    check("empty_pop_requests", empty_pop, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
